multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle main-control FSM for the MIPS-subset datapath. It decodes the 6-bit opcode, sequences each instruction through fetch, decode, execute, memory and writeback, and drives the 3-bit ALU operation class consumed by the ALU control decoder. It also drives the enables for the PC, IR, memory and register file, and stalls on a memory ready handshake.

## Interface
- No parameters; all widths fixed.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state FETCH
- Opcode  in  6  IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag, sampled in BRANCH
- MemReady  in  1  memory handshake; access completes in the cycle it is 1
- ALUOp  out  3  ALU operation class: 111 R-type, 101 addi, 100 slti, 011 andi, 010 ori, 001 add (lw/sw/PC+4), 000 beq
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = zero-extended imm
- IorD  out  1  memory address from 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite, PCWrite  out  1 each  load IR; load PC with ALU result
- PCWriteBr  out  1  load PC with ALUOut (branch target); asserted only when branch taken
- RegWrite, RegDst, MemToReg  out  1 each  RF write enable; 1 = rd else rt; 1 = MDR else ALUOut
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- Illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
- State  out  4  current state code, for debug

## Operation
- States and codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9.
- Supported opcodes: R 000000, addi 001000, slti 001010, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100.
- Moore outputs are decoded from the state register only. Any output not listed for a state is 0, and ALUOp defaults to 001.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=001.
  - While MemReady=0: stay in FETCH, IRWrite=0, PCWrite=0.
  - When MemReady=1: IRWrite=1, PCWrite=1, next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=001 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → EXEC_R
  - addi/slti/andi/ori → EXEC_I
  - beq → BRANCH
  - any other opcode → FETCH with Illegal=1 and InstrDone=0
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=001. Next state MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ: MemRead=1, IorD=1. Holds until MemReady, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemToReg=1, InstrDone=1. Next state FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until MemReady; when MemReady=1, InstrDone=1 and next state FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next state ALU_WB.
- EXEC_I: ALUSrcA=1, ALUOp from opcode (addi 101, slti 100, andi 011, ori 010).
  - ALUSrcB=10 for addi/slti, 11 for andi/ori.
  - Next state ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0, RegDst=1 for R else 0, InstrDone=1. Next state FETCH.
  - Opcode is held stable by the IR, so RegDst can be decoded from it.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=000, PCWriteBr=Zero, InstrDone=1. Next state FETCH.
- Opcode is only interpreted in DECODE, MEM_ADDR, EXEC_I and ALU_WB. Its value in other states is a don't-care.

## Timing
- Reset (asynchronous, immediate): state=FETCH. The FETCH outputs appear immediately:
  - MemRead=1, ALUSrcB=01, ALUOp=001
  - all other outputs 0, State=0
  - IRWrite and PCWrite follow MemReady combinationally.
- Reset asserted mid-instruction abandons it: no RegWrite, MemWrite or InstrDone pulse after the reset edge.
- Cycles per instruction with MemReady held at 1:
  - lw 5
  - sw 4
  - R and I-type ALU 4
  - beq 3
  - illegal opcode 2
- Each cycle of MemReady=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. No strobe is dropped while stalled.
- The single-cycle PCWrite and IRWrite pulse coincides with MemReady=1 in FETCH. There is never more than one PCWrite per instruction.
- PCWrite and PCWriteBr are never asserted together.

## Test plan
- Reset with MemReady=1: State=0, MemRead=1, IRWrite=1, PCWrite=1. Deassert reset → DECODE on the next edge.
- addi (001000), MemReady=1: states 0,1,7,8,0. ALUOp=101 and ALUSrcB=10 in state 7. RegWrite=1, RegDst=0 and InstrDone=1 in state 8.
- lw with MemReady low for 2 cycles in MEM_READ: states 0,1,2,3,3,3,4,0. MemRead and IorD stay 1 throughout state 3. RegWrite and MemToReg are 1 in state 4.
- beq run twice, with Zero=1 then Zero=0: PCWriteBr=1 then 0 in state 9, ALUOp=000. Each takes 3 cycles.
- Opcode 111111: Illegal=1 in DECODE, InstrDone=0, back to FETCH after 2 cycles. No RegWrite or MemWrite.
- sw with reset pulsed during MEM_WRITE and MemReady=0: State=0 immediately, MemWrite drops to 0, no InstrDone pulse.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main-control FSM and the MIPS-subset datapath.
// The control FSM is the master: it samples Opcode/Zero/MemReady and drives every strobe.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteBr;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       InstrDone;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, Zero, MemReady,
    output ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite,
           PCWriteBr, RegWrite, RegDst, MemToReg, InstrDone, Illegal, State
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite,
           PCWriteBr, RegWrite, RegDst, MemToReg, InstrDone, Illegal, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle main-control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on MemReady in the memory-access states and drives all datapath enables.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  state_t state_reg, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  assign bus.State = state_reg;

  always_comb begin
    state_next    = state_reg;
    bus.ALUOp     = 3'b001;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.PCWriteBr = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemToReg  = 1'b0;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;

    case (state_reg)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        // IR and PC load only in the cycle the memory actually returns the word
        if (bus.MemReady) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_next  = DECODE;
        end
      end
      DECODE: begin
        bus.ALUSrcB = 2'b10;
        case (bus.Opcode)
          OP_LW, OP_SW:                       state_next = MEM_ADDR;
          OP_R:                               state_next = EXEC_R;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_next = EXEC_I;
          OP_BEQ:                             state_next = BRANCH;
          default: begin
            bus.Illegal = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_next  = (bus.Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.MemReady) state_next = MEM_WB;
      end
      MEM_WB: begin
        bus.RegWrite  = 1'b1;
        bus.MemToReg  = 1'b1;
        bus.InstrDone = 1'b1;
        state_next    = FETCH;
      end
      MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.MemReady) begin
          bus.InstrDone = 1'b1;
          state_next    = FETCH;
        end
      end
      EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 3'b111;
        state_next  = ALU_WB;
      end
      EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (bus.Opcode)
          OP_ADDI: bus.ALUOp = 3'b101;
          OP_SLTI: bus.ALUOp = 3'b100;
          OP_ANDI: begin bus.ALUOp = 3'b011; bus.ALUSrcB = 2'b11; end
          OP_ORI:  begin bus.ALUOp = 3'b010; bus.ALUSrcB = 2'b11; end
          default: bus.ALUOp = 3'b001;
        endcase
        state_next = ALU_WB;
      end
      ALU_WB: begin
        bus.RegWrite  = 1'b1;
        bus.RegDst    = (bus.Opcode == OP_R);
        bus.InstrDone = 1'b1;
        state_next    = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUOp     = 3'b000;
        bus.PCWriteBr = bus.Zero;
        bus.InstrDone = 1'b1;
        state_next    = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-path model checked every cycle,
// plus directed instruction runs with hand-written state traces and cycle counts.
module tb_multicycle_control;

  logic clk;
  logic reset;
  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remaining states after DECODE for each opcode, low nibble first.
  function automatic logic [15:0] path_of(input logic [5:0] op);
    case (op)
      6'b100011:                                  return 16'h0432;
      6'b101011:                                  return 16'h0052;
      6'b000000:                                  return 16'h0086;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return 16'h0087;
      6'b000100:                                  return 16'h0009;
      default:                                    return 16'h0000;
    endcase
  endfunction

  function automatic int len_of(input logic [5:0] op);
    case (op)
      6'b100011:                                  return 3;
      6'b101011, 6'b000000,
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return 2;
      6'b000100:                                  return 1;
      default:                                    return 0;
    endcase
  endfunction

  // Expected output word for a given state code and inputs.
  function automatic logic [31:0] exp_word(input logic [3:0] s, input logic [5:0] op,
                                           input logic mr, input logic z);
    logic [2:0] aluop;
    logic       srca, iord, mrd, mwr, irw, pcw, pcbr, rw, rdst, m2r, done, ill;
    logic [1:0] srcb;
    aluop = 3'b001; srca = 0; srcb = 2'b00; iord = 0; mrd = 0; mwr = 0; irw = 0;
    pcw = 0; pcbr = 0; rw = 0; rdst = 0; m2r = 0; done = 0; ill = 0;
    case (s)
      4'd0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1: begin srcb = 2'b10; ill = (len_of(op) == 0); end
      4'd2: begin srca = 1; srcb = 2'b10; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; done = 1; end
      4'd5: begin mwr = 1; iord = 1; done = mr; end
      4'd6: begin srca = 1; aluop = 3'b111; end
      4'd7: begin
        srca = 1;
        aluop = (op == 6'b001000) ? 3'b101 : (op == 6'b001010) ? 3'b100 :
                (op == 6'b001100) ? 3'b011 : 3'b010;
        srcb = (op == 6'b001100 || op == 6'b001101) ? 2'b11 : 2'b10;
      end
      4'd8: begin rw = 1; rdst = (op == 6'b000000); done = 1; end
      4'd9: begin srca = 1; aluop = 3'b000; pcbr = z; done = 1; end
      default: ;
    endcase
    return {11'd0, aluop, srca, srcb, iord, mrd, mwr, irw, pcw, pcbr, rw, rdst, m2r,
            done, ill, s};
  endfunction

  function automatic logic [31:0] dut_word();
    return {11'd0, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.PCWriteBr, bus.RegWrite,
            bus.RegDst, bus.MemToReg, bus.InstrDone, bus.Illegal, bus.State};
  endfunction

  // Model: current state plus the pending list of states for this instruction.
  logic [3:0]  m_state = 4'd0;
  logic [15:0] m_path  = 16'h0;
  int          m_len   = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 4'd0;
      m_path  <= 16'h0;
      m_len   <= 0;
    end else if ((m_state == 4'd0 || m_state == 4'd3 || m_state == 4'd5) && !bus.MemReady) begin
      m_state <= m_state;
    end else if (m_state == 4'd0) begin
      m_state <= 4'd1;
    end else if (m_state == 4'd1) begin
      if (len_of(bus.Opcode) == 0) begin
        m_state <= 4'd0;
      end else begin
        m_state <= path_of(bus.Opcode) & 16'h000F;
        m_path  <= path_of(bus.Opcode) >> 4;
        m_len   <= len_of(bus.Opcode) - 1;
      end
    end else if (m_len == 0) begin
      m_state <= 4'd0;
    end else begin
      m_state <= m_path[3:0];
      m_path  <= m_path >> 4;
      m_len   <= m_len - 1;
    end
  end

  always @(negedge clk) begin
    check("outputs_vs_model", dut_word(), exp_word(m_state, bus.Opcode, bus.MemReady, bus.Zero));
    if (bus.InstrDone) done_cnt++;
  end

  // Called just after a rising edge with the DUT in FETCH. mr_mask bit c is
  // MemReady in cycle c; exp_seq nibble c is the required State in cycle c.
  task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                           input logic [15:0] mr_mask, input logic [63:0] exp_seq,
                           input int exp_cycles);
    int  cycles = 0;
    int  pcw_cnt = 0;
    bit  finished = 0;
    for (int c = 0; c < 24 && !finished; c++) begin
      bus.Opcode   = op;
      bus.Zero     = z;
      bus.MemReady = mr_mask[c % 16];
      @(negedge clk);
      if (c < exp_cycles) check({name, "_state"}, {28'd0, bus.State}, {28'd0, exp_seq[4*c +: 4]});
      if (bus.PCWrite) pcw_cnt++;
      if (bus.InstrDone || bus.Illegal) begin
        finished = 1;
        cycles   = c + 1;
      end
      @(posedge clk);
      #1;
    end
    if (!finished) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_cycles"}, cycles, exp_cycles);
    check({name, "_pcwrite_count"}, pcw_cnt, 1);
    if (len_of(op) != 0) exp_done++;
    $display("instr %-10s op=%b zero=%0d cycles=%0d (expected %0d)", name, op, z, cycles, exp_cycles);
  endtask

  initial begin
    reset        = 1'b1;
    bus.Opcode   = 6'b000000;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b1;

    @(negedge clk);
    check("reset_state",    {28'd0, bus.State}, 32'd0);
    check("reset_memread",  {31'd0, bus.MemRead}, 32'd1);
    check("reset_irwrite",  {31'd0, bus.IRWrite}, 32'd1);
    check("reset_pcwrite",  {31'd0, bus.PCWrite}, 32'd1);
    check("reset_alusrcb",  {30'd0, bus.ALUSrcB}, 32'd1);
    check("reset_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    bus.MemReady = 1'b0;
    #1;
    check("reset_irwrite_follows_ready", {31'd0, bus.IRWrite}, 32'd0);
    bus.MemReady = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr("addi",      6'b001000, 1'b0, 16'hFFFF, 64'h8710,    4);
    run_instr("addi_fst",  6'b001000, 1'b0, 16'hFFFE, 64'h87100,   5);
    run_instr("slti",      6'b001010, 1'b0, 16'hFFFF, 64'h8710,    4);
    run_instr("andi",      6'b001100, 1'b0, 16'hFFFF, 64'h8710,    4);
    run_instr("ori",       6'b001101, 1'b0, 16'hFFFF, 64'h8710,    4);
    run_instr("rtype",     6'b000000, 1'b0, 16'hFFFF, 64'h8610,    4);
    run_instr("lw",        6'b100011, 1'b0, 16'hFFFF, 64'h43210,   5);
    run_instr("lw_stall",  6'b100011, 1'b0, 16'hFFE7, 64'h4333210, 7);
    run_instr("sw",        6'b101011, 1'b0, 16'hFFFF, 64'h5210,    4);
    run_instr("sw_stall",  6'b101011, 1'b0, 16'hFFF7, 64'h55210,   5);
    run_instr("beq_taken", 6'b000100, 1'b1, 16'hFFFF, 64'h910,     3);
    run_instr("beq_not",   6'b000100, 1'b0, 16'hFFFF, 64'h910,     3);
    run_instr("illegal",   6'b111111, 1'b0, 16'hFFFF, 64'h10,      2);

    // sw abandoned by reset while stalled in MEM_WRITE
    bus.Opcode = 6'b101011;
    for (int c = 0; c < 4; c++) begin
      bus.MemReady = (c == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 3) begin
        check("swrst_pre_state",    {28'd0, bus.State}, 32'd5);
        check("swrst_pre_memwrite", {31'd0, bus.MemWrite}, 32'd1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    reset = 1'b1;
    #1;
    check("swrst_state",     {28'd0, bus.State}, 32'd0);
    check("swrst_memwrite",  {31'd0, bus.MemWrite}, 32'd0);
    check("swrst_instrdone", {31'd0, bus.InstrDone}, 32'd0);
    check("swrst_memread",   {31'd0, bus.MemRead}, 32'd1);
    $display("instr %-10s op=%b aborted by reset in MEM_WRITE", "sw_reset", bus.Opcode);
    bus.MemReady = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr("rtype_post", 6'b000000, 1'b0, 16'hFFFF, 64'h8610, 4);

    check("instrdone_total", done_cnt, exp_done);
    check("instrdone_literal", done_cnt, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
